// File: rtl/game_pkg.sv
// Shared game definitions: ball slot states, ball size range and default point values.
package game_pkg;

    typedef enum logic [2:0] {
        SLOT_IDLE     = 3'd0,
        SLOT_ARMING   = 3'd1,
        SLOT_ALIVE    = 3'd2,
        SLOT_COOLDOWN = 3'd3,
        SLOT_POPPED   = 3'd4
    } slot_state_t;

    localparam logic [1:0]  MIN_SIZE          = 2'd0;
    localparam logic [1:0]  MAX_SIZE          = 2'd3;
    localparam logic [7:0]  DEF_SHRINK_POINTS = 8'd5;
    localparam logic [7:0]  DEF_POP_POINTS    = 8'd10;
    localparam logic [15:0] DEF_COOL_CYCLES   = 16'd50000;

endpackage

// File: rtl/ball_slot_controller_if.sv
// Per-slot spawn/score/status bundle between the level controller side and one ball slot.
interface ball_slot_controller_if;
    logic       enable;
    logic       spawnActive;
    logic [1:0] spawnSize;
    logic       secClk;
    logic       hit;
    logic       inUse;
    logic       visible;
    logic [1:0] size;
    logic       scoreValid;
    logic [7:0] scoreValue;
    logic [2:0] slotState;

    modport master (
        output enable, spawnActive, spawnSize, secClk, hit,
        input  inUse, visible, size, scoreValid, scoreValue, slotState
    );

    modport slave (
        input  enable, spawnActive, spawnSize, secClk, hit,
        output inUse, visible, size, scoreValid, scoreValue, slotState
    );
endinterface

// File: rtl/rise_edge_detect.sv
// Single-register rising-edge detector; pulse is high for the clk where in first reads 1.
module rise_edge_detect (
    input  logic clk,
    input  logic resetN,
    input  logic in,
    output logic pulse
);
    logic in_q, in_d;

    always_comb in_d = in;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) in_q <= 1'b0;
        else         in_q <= in_d;
    end

    assign pulse = in & ~in_q;
endmodule

// File: rtl/ball_slot_controller.sv
// One ball slot: accepts a spawn, runs arming/alive/cooldown/pop and emits score strobes.
//   state    | meaning
//   IDLE     | slot free, waiting for a spawn edge
//   ARMING   | ball reserved but invisible, counting secClk edges
//   ALIVE    | ball drawn and hittable
//   COOLDOWN | ball drawn, immune to hits after a shrink
//   POPPED   | one clk: pop score strobe, slot still in use
module ball_slot_controller
    import game_pkg::*;
#(
    parameter int unsigned  SPAWN_DELAY   = 2,
    parameter logic [15:0]  COOL_CYCLES   = DEF_COOL_CYCLES,
    parameter logic [7:0]   SHRINK_POINTS = DEF_SHRINK_POINTS,
    parameter logic [7:0]   POP_POINTS    = DEF_POP_POINTS
) (
    input  logic                  clk,
    input  logic                  resetN,
    ball_slot_controller_if.slave bus
);
    localparam logic [2:0] ST_IDLE     = SLOT_IDLE;
    localparam logic [2:0] ST_ARMING   = SLOT_ARMING;
    localparam logic [2:0] ST_ALIVE    = SLOT_ALIVE;
    localparam logic [2:0] ST_COOLDOWN = SLOT_COOLDOWN;
    localparam logic [2:0] ST_POPPED   = SLOT_POPPED;
    localparam logic [3:0] TICK_TARGET = 4'(SPAWN_DELAY);

    if (SPAWN_DELAY > 15) begin : g_bad_spawn_delay
        $error("SPAWN_DELAY must not exceed 15");
    end
    if (COOL_CYCLES == 16'd0) begin : g_bad_cool_cycles
        $error("COOL_CYCLES must be at least 1");
    end

    logic spawn_edge, sec_edge;

    rise_edge_detect u_spawn_edge (.clk(clk), .resetN(resetN), .in(bus.spawnActive), .pulse(spawn_edge));
    rise_edge_detect u_sec_edge   (.clk(clk), .resetN(resetN), .in(bus.secClk),      .pulse(sec_edge));

    logic [2:0]  state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [15:0] cool_q, cool_d;
    logic [3:0]  tick_q, tick_d;
    logic [3:0]  tick_inc;
    logic        in_use_q, in_use_d;
    logic        visible_q, visible_d;
    logic        score_valid_q, score_valid_d;
    logic [7:0]  score_value_q, score_value_d;

    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        cool_d        = cool_q;
        tick_d        = tick_q;
        score_valid_d = 1'b0;
        score_value_d = 8'd0;
        tick_inc      = tick_q + {3'b000, sec_edge};

        if (!bus.enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (spawn_edge) begin
                        state_d = ST_ARMING;
                        size_d  = bus.spawnSize;
                        tick_d  = 4'd0;
                    end
                end
                ST_ARMING: begin
                    tick_d = tick_inc;
                    // Zero delay still spends exactly one clk here, whatever secClk does.
                    if (SPAWN_DELAY == 0 || tick_inc == TICK_TARGET) state_d = ST_ALIVE;
                end
                ST_ALIVE: begin
                    if (bus.hit) begin
                        if (size_q != MIN_SIZE) begin
                            state_d       = ST_COOLDOWN;
                            size_d        = size_q - 2'd1;
                            cool_d        = COOL_CYCLES - 16'd1;
                            score_valid_d = 1'b1;
                            score_value_d = SHRINK_POINTS;
                        end else begin
                            state_d = ST_POPPED;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (cool_q == 16'd0) state_d = ST_ALIVE;
                    else                 cool_d  = cool_q - 16'd1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d == ST_POPPED) begin
            score_valid_d = 1'b1;
            score_value_d = POP_POINTS;
        end
        in_use_d  = (state_d != ST_IDLE);
        visible_d = (state_d == ST_ALIVE) || (state_d == ST_COOLDOWN);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            size_q        <= 2'd0;
            cool_q        <= 16'd0;
            tick_q        <= 4'd0;
            in_use_q      <= 1'b0;
            visible_q     <= 1'b0;
            score_valid_q <= 1'b0;
            score_value_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            cool_q        <= cool_d;
            tick_q        <= tick_d;
            in_use_q      <= in_use_d;
            visible_q     <= visible_d;
            score_valid_q <= score_valid_d;
            score_value_q <= score_value_d;
        end
    end

    assign bus.inUse      = in_use_q;
    assign bus.visible    = visible_q;
    assign bus.size       = size_q;
    assign bus.scoreValid = score_valid_q;
    assign bus.scoreValue = score_value_q;
    assign bus.slotState  = state_q;
endmodule

// File: tb/tb_ball_slot_controller.sv
// Bench for ball_slot_controller: two slots (arming delay 2 and 0) share one stimulus stream.
module tb_ball_slot_controller;
    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       enable = 1'b0;
    logic       spawnActive = 1'b0;
    logic [1:0] spawnSize = 2'd0;
    logic       secClk = 1'b0;
    logic       hit = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ball_slot_controller_if if_a ();
    ball_slot_controller_if if_b ();

    assign if_a.enable = enable;      assign if_b.enable = enable;
    assign if_a.spawnActive = spawnActive; assign if_b.spawnActive = spawnActive;
    assign if_a.spawnSize = spawnSize;    assign if_b.spawnSize = spawnSize;
    assign if_a.secClk = secClk;      assign if_b.secClk = secClk;
    assign if_a.hit = hit;            assign if_b.hit = hit;

    ball_slot_controller #(.SPAWN_DELAY(2), .COOL_CYCLES(16'd4), .SHRINK_POINTS(8'd5), .POP_POINTS(8'd10))
        dut_a (.clk(clk), .resetN(resetN), .bus(if_a));
    ball_slot_controller #(.SPAWN_DELAY(0), .COOL_CYCLES(16'd4), .SHRINK_POINTS(8'd5), .POP_POINTS(8'd10))
        dut_b (.clk(clk), .resetN(resetN), .bus(if_b));

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: phase numbers double as the slotState values to expect.
    localparam int P_IDLE = 0, P_ARM = 1, P_ALIVE = 2, P_COOL = 3, P_POP = 4;
    int p_delay [2] = '{2, 0};
    int p_cool  [2] = '{4, 4};
    int m_phase [2];
    int m_size  [2];
    int m_left  [2];
    int m_ticks [2];
    int m_pspawn[2];
    int m_psec  [2];
    int m_sv    [2];
    int m_val   [2];

    task automatic model_reset(input int k);
        m_phase[k] = P_IDLE; m_size[k] = 0; m_left[k] = 0; m_ticks[k] = 0;
        m_pspawn[k] = 0; m_psec[k] = 0; m_sv[k] = 0; m_val[k] = 0;
    endtask

    task automatic model_step(input int k);
        bit spawn_e, sec_e;
        spawn_e = spawnActive && (m_pspawn[k] == 0);
        sec_e   = secClk && (m_psec[k] == 0);
        m_pspawn[k] = int'(spawnActive);
        m_psec[k]   = int'(secClk);
        m_sv[k] = 0;
        m_val[k] = 0;
        if (!enable) begin
            m_phase[k] = P_IDLE;
        end else if (m_phase[k] == P_IDLE) begin
            if (spawn_e) begin
                m_phase[k] = P_ARM; m_size[k] = int'(spawnSize); m_ticks[k] = 0;
            end
        end else if (m_phase[k] == P_ARM) begin
            if (sec_e) m_ticks[k]++;
            if (p_delay[k] == 0 || m_ticks[k] >= p_delay[k]) m_phase[k] = P_ALIVE;
        end else if (m_phase[k] == P_ALIVE) begin
            if (hit && m_size[k] > 0) begin
                m_size[k]--; m_left[k] = p_cool[k]; m_phase[k] = P_COOL;
                m_sv[k] = 1; m_val[k] = 5;
            end else if (hit) begin
                m_phase[k] = P_POP; m_sv[k] = 1; m_val[k] = 10;
            end
        end else if (m_phase[k] == P_COOL) begin
            m_left[k]--;
            if (m_left[k] == 0) m_phase[k] = P_ALIVE;
        end else begin
            m_phase[k] = P_IDLE;
        end
    endtask

    task automatic cmp(input string tag, input int k, input logic in_use, input logic vis,
                       input logic [1:0] sz, input logic sv, input logic [7:0] val, input logic [2:0] st);
        chk({tag, ".slotState"}, int'(st), m_phase[k]);
        chk({tag, ".inUse"}, int'(in_use), int'(m_phase[k] != P_IDLE));
        chk({tag, ".visible"}, int'(vis), int'(m_phase[k] == P_ALIVE || m_phase[k] == P_COOL));
        chk({tag, ".size"}, int'(sz), m_size[k]);
        chk({tag, ".scoreValid"}, int'(sv), m_sv[k]);
        chk({tag, ".scoreValue"}, int'(val), m_val[k]);
    endtask

    int cyc = 0;
    bit win = 1'b0;
    int strobe_vals[$];
    int strobe_cycs[$];

    always @(posedge clk) begin
        cyc++;
        if (!resetN) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
        #1;
        cmp("A", 0, if_a.inUse, if_a.visible, if_a.size, if_a.scoreValid, if_a.scoreValue, if_a.slotState);
        cmp("B", 1, if_b.inUse, if_b.visible, if_b.size, if_b.scoreValid, if_b.scoreValue, if_b.slotState);
        if (win && if_a.scoreValid) begin
            strobe_vals.push_back(int'(if_a.scoreValue));
            strobe_cycs.push_back(cyc);
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sec_pulse();
        secClk = 1'b1; clocks(1);
        secClk = 1'b0; clocks(1);
    endtask

    initial begin
        clocks(2);
        resetN = 1'b1;
        chk("reset.inUse", int'(if_a.inUse), 0);
        chk("reset.slotState", int'(if_a.slotState), 0);
        chk("reset.scoreValid", int'(if_a.scoreValid), 0);

        // Spawn size 2 and arm for two secClk edges; a hit while arming does nothing.
        enable = 1'b1; clocks(1);
        spawnSize = 2'd2; spawnActive = 1'b1; clocks(1);
        chk("spawn.inUse", int'(if_a.inUse), 1);
        chk("spawn.size", int'(if_a.size), 2);
        chk("spawn.slotState", int'(if_a.slotState), 1);
        secClk = 1'b1; clocks(1);
        secClk = 1'b0; hit = 1'b1; clocks(1);
        hit = 1'b0; clocks(1);
        chk("arm_hit.slotState", int'(if_a.slotState), 1);
        chk("arm_hit.size", int'(if_a.size), 2);
        chk("arm_hit.scoreValid", int'(if_a.scoreValid), 0);
        secClk = 1'b1; clocks(1);
        chk("alive.visible", int'(if_a.visible), 1);
        chk("alive.slotState", int'(if_a.slotState), 2);
        secClk = 1'b0;

        // Shrink to size 1, then spawnActive chatter while alive.
        hit = 1'b1; clocks(1);
        hit = 1'b0; clocks(6);
        for (int i = 0; i < 8; i++) begin
            spawnActive = ~spawnActive; clocks(1);
        end
        chk("toggle.slotState", int'(if_a.slotState), 2);
        chk("toggle.size", int'(if_a.size), 1);
        spawnActive = 1'b0; clocks(1);

        // Held hit on a size-1 ball: shrink strobe, four cooldown clocks, one alive clk, pop.
        win = 1'b1; hit = 1'b1; clocks(20);
        win = 1'b0; hit = 1'b0;
        chk("held.strobes", strobe_vals.size(), 2);
        if (strobe_vals.size() == 2) begin
            chk("held.first_value", strobe_vals[0], 5);
            chk("held.second_value", strobe_vals[1], 10);
            chk("held.strobe_gap", strobe_cycs[1] - strobe_cycs[0], 5);
        end
        chk("held.inUse", int'(if_a.inUse), 0);
        chk("held.slotState", int'(if_a.slotState), 0);

        // Abort in cooldown via enable, then respawn.
        spawnSize = 2'd3; spawnActive = 1'b1; clocks(1);
        sec_pulse(); sec_pulse();
        hit = 1'b1; clocks(1);
        hit = 1'b0;
        chk("abort.pre_state", int'(if_a.slotState), 3);
        enable = 1'b0; spawnActive = 1'b0; clocks(1);
        chk("abort.slotState", int'(if_a.slotState), 0);
        chk("abort.inUse", int'(if_a.inUse), 0);
        chk("abort.visible", int'(if_a.visible), 0);
        chk("abort.scoreValid", int'(if_a.scoreValid), 0);
        chk("abort.size_hold", int'(if_a.size), 2);
        enable = 1'b1; spawnSize = 2'd1; spawnActive = 1'b1; clocks(1);
        chk("respawn.slotState", int'(if_a.slotState), 1);
        chk("respawn.size", int'(if_a.size), 1);
        enable = 1'b0; spawnActive = 1'b0; clocks(2);

        // Spawn and hit together in IDLE; zero-delay slot is alive one clk later.
        enable = 1'b1; spawnActive = 1'b1; spawnSize = 2'd1; hit = 1'b1; clocks(1);
        hit = 1'b0;
        chk("spawn_hit.B_state", int'(if_b.slotState), 1);
        chk("spawn_hit.B_size", int'(if_b.size), 1);
        chk("spawn_hit.B_scoreValid", int'(if_b.scoreValid), 0);
        chk("spawn_hit.A_scoreValid", int'(if_a.scoreValid), 0);
        clocks(1);
        chk("delay0.B_state", int'(if_b.slotState), 2);
        chk("delay0.B_visible", int'(if_b.visible), 1);
        chk("delay0.A_state", int'(if_a.slotState), 1);
        clocks(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ball_slot_controller.md
Name: ball_slot_controller

Overview:
- Consumer end of the level controller's per-ball spawn interface; one instance per ball slot (three in the game).
- Detects a spawn request as a rising edge on spawnActive, latches the requested initial size, and holds inUse high for the whole ball lifetime so the level controller stops requesting.
- Runs the ball lifecycle: arming delay, alive, post-hit cooldown, pop. Emits score pulses toward the score accumulator.

Parameters:
- SPAWN_DELAY, 2, secClk rising edges spent in ARMING (invisible) before the ball goes ALIVE; 0 means one clk in ARMING.
- COOL_CYCLES, 16'd50000, clk cycles of hit immunity after a shrink; minimum 1.
- SHRINK_POINTS, 8'd5, scoreValue emitted when a size>0 ball is hit.
- POP_POINTS, 8'd10, scoreValue emitted when a size-0 ball is hit.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- enable  in  1  game running; low forces the slot idle
- spawnActive  in  1  spawn request from the level controller; toggles while the slot is not inUse
- spawnSize  in  2  requested initial size (0 smallest .. 3 largest)
- secClk  in  1  slow timebase, sampled synchronously
- hit  in  1  shot/ball collision, level, synchronous
- inUse  out  1  slot occupied (ARMING, ALIVE, COOLDOWN, POPPED)
- visible  out  1  ball drawn (ALIVE, COOLDOWN)
- size  out  2  current ball size
- scoreValid  out  1  one-clk score strobe
- scoreValue  out  8  points for the strobe; 0 when scoreValid=0
- slotState  out  3  encoded current state (debug / OSD)

Behaviour:
- Clock and reset: reset resetN, asynchronous, active-low; clock clk.
- Reset values: state IDLE, inUse=0, visible=0, size=0, scoreValid=0, scoreValue=0, slotState=IDLE. Both edge-detect registers=0. Cooldown counter=0. Arming tick counter=0.
- All outputs are registered. They are decoded from the next state, so each takes its new value on the same edge the state changes.
- spawnEdge = spawnActive & ~spawnActive_d. secEdge = secClk & ~secClk_d. Both delayed registers update every clk, independent of state.
- Priority, highest first:
  - enable=0 → state IDLE on the next edge, from any state. No score strobe. size holds. Edge registers keep updating.
  - Otherwise, use the per-state rules below.
- IDLE:
  - spawnEdge=1 → ARMING. Latch size=spawnSize, clear the tick counter, inUse=1 on that edge.
  - hit is ignored.
- ARMING:
  - Each secEdge increments the tick counter.
  - When tick counter = SPAWN_DELAY (checked including the current secEdge) → ALIVE, visible=1.
  - With SPAWN_DELAY=0, leave after exactly one clk.
  - hit and spawnEdge are ignored.
- ALIVE:
  - hit=1 and size>0 → COOLDOWN. size=size-1, load the cooldown counter with COOL_CYCLES-1, one-clk strobe scoreValid=1 with scoreValue=SHRINK_POINTS.
  - hit=1 and size=0 → POPPED, visible=0.
- COOLDOWN:
  - Counter decrements every clk; hit is ignored.
  - At counter=0 → ALIVE. A hit still high on that edge is not acted on until the next cycle in ALIVE.
- POPPED (one clk):
  - scoreValid=1, scoreValue=POP_POINTS, inUse=1.
  - Next edge → IDLE, inUse=0.
- spawnEdge outside IDLE is ignored (not queued).
- A spawnEdge on the first IDLE cycle after POPPED or an abort is accepted normally.
- A held-high hit pops a size-s ball no faster than s·COOL_CYCLES + s + 1 clk, never two strobes on consecutive cycles.
- Counter widths: cooldown 16 bit, tick counter 4 bit. SPAWN_DELAY ≤ 15 (elaboration-time assertion).
- slotState encoding: IDLE=0, ARMING=1, ALIVE=2, COOLDOWN=3, POPPED=4.

Decomposition:
- Shared package game_pkg holds:
  - the slot_state_t enum (logic [2:0], encodings above);
  - the ball size range constants MIN_SIZE=0 and MAX_SIZE=3;
  - default point constants.
- One natural sub-module: rise_edge_detect (clk, resetN, in → pulse, one-register delay), instantiated twice (spawnActive, secClk).

Test Plan:
- Reset, then one 0→1 step on spawnActive with spawnSize=2, enable=1 → next edge inUse=1, size=2, slotState=1. After 2 secClk rising edges: visible=1, slotState=2.
- ALIVE at size 1, hit held high for 20 clk, COOL_CYCLES=4, SHRINK_POINTS=5, POP_POINTS=10:
  - one strobe of 5, size=0;
  - after 4 clk in COOLDOWN, back to ALIVE;
  - one clk later POPPED with a strobe of 10;
  - then inUse=0. Exactly 2 strobes total.
- Drop enable in COOLDOWN → next edge slotState=0, inUse=0, visible=0, scoreValid=0. Re-raise enable plus a spawn edge → ARMING normally.
- spawnActive toggling every clk while ALIVE → state, size and strobes unchanged. hit during ARMING → no strobe, no size change.
- SPAWN_DELAY=0 → ARMING lasts exactly 1 clk, then ALIVE with visible=1.
- Spawn edge and hit on the same IDLE cycle → ARMING entered, size=spawnSize, no strobe.
